// File: rtl/m31_pkg.sv
// m31_pkg: shared M31 field types, default Poseidon2 geometry and round constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: m31_t, P_M31, M31_WIDTH/M31_RF/M31_RP, ark_state_e, RC_EXT[RF][WIDTH], RC_INT[RP].
package m31_pkg;

  typedef logic [30:0] m31_t;

  localparam m31_t P_M31 = 31'h7FFFFFFF;

  localparam int M31_WIDTH = 16;
  localparam int M31_RF    = 8;
  localparam int M31_RP    = 14;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ark_state_e;

  // External-round constants: rows 0..RF/2-1 feed the first full half,
  // rows RF/2..RF-1 feed the second full half.
  localparam m31_t RC_EXT [M31_RF][M31_WIDTH] = '{
    '{31'h2C1E6B0D, 31'h0F3A9E27, 31'h5D841C63, 31'h1B7F02A9,
      31'h6E25D4F1, 31'h3A907C1E, 31'h47D38B52, 31'h0886E3C4,
      31'h71235A9F, 31'h24F8C017, 31'h5B6E93D8, 31'h1D074F2A,
      31'h6C49B185, 31'h3F126ED0, 31'h0A5D2897, 31'h58B4F30C},
    '{31'h139A7E52, 31'h66C0D1B8, 31'h2F5B0A43, 31'h4A81E97D,
      31'h05D3C62E, 31'h7B2F1490, 31'h38E6A5D1, 31'h1C04B73F,
      31'h62A9F085, 31'h0B7D3C16, 31'h49F2E8A3, 31'h2651047B,
      31'h73C8B9E0, 31'h158E6D24, 31'h5A3710CF, 31'h3E94A256},
    '{31'h4D0B8F31, 31'h1287C5EA, 31'h6F53A07C, 31'h0964D2B8,
      31'h35BE1F47, 31'h57A0C39D, 31'h21F6840E, 31'h7C3D5B92,
      31'h0E8A27F5, 31'h44C19B6A, 31'h6A0F7D13, 31'h1F52E8C9,
      31'h3B7904A6, 31'h50D6B21F, 31'h07A3E9C4, 31'h692C5F38},
    '{31'h187E43B9, 31'h5C21F06D, 31'h03B9A8E2, 31'h71D46C57,
      31'h2A6F1D80, 31'h4E8B35F4, 31'h16C2D0A9, 31'h6B5709E3,
      31'h3390BC6F, 31'h0D47E815, 31'h7516A2CB, 31'h28DF6470,
      31'h4C02B9D6, 31'h1A7D3E28, 31'h60E9F51B, 31'h3785A0C4},
    '{31'h5E31C7A2, 31'h0BF4902D, 31'h46A81E7B, 31'h2D05F3C6,
      31'h709B6418, 31'h19E2D7A5, 31'h63574B0E, 31'h04C8A293,
      31'h3AF610D8, 31'h552B8C41, 31'h0F9E37B6, 31'h6840D52C,
      31'h2273E9F0, 31'h4BA65C17, 31'h11D80A7E, 31'h7E0B4392},
    '{31'h09C4D86B, 31'h6D3A215E, 31'h31F79CB0, 31'h578E0A43,
      31'h1E25B7D9, 31'h74D0638C, 31'h2B69F115, 31'h4097C4AE,
      31'h66E21B57, 31'h138A5FC3, 31'h5F4DA820, 31'h0A317E69,
      31'h39C6D0F4, 31'h725B8A1D, 31'h25E04369, 31'h4F13B7C2},
    '{31'h6A87F21C, 31'h170DC5A3, 31'h4C6B0E98, 31'h03F29D47,
      31'h58A4361E, 31'h2E71C8B5, 31'h7B0945DA, 31'h1436E27F,
      31'h41D8AB03, 31'h6F25704C, 31'h08BC19E6, 31'h32E6D5A1,
      31'h5D71F83B, 31'h1C9E4270, 31'h67435BC8, 31'h2A08E615},
    '{31'h35D2A947, 31'h7E46118B, 31'h0CA5F3D2, 31'h5198E06A,
      31'h26FB4C15, 31'h6A3207E9, 31'h1F8DB54C, 31'h43601A97,
      31'h0751E8F3, 31'h5C8A2B60, 31'h38F7D41E, 31'h6E13A5C9,
      31'h14B67F02, 31'h497C0D83, 31'h7229B6E4, 31'h0B5E4C3A}
  };

  // Internal-round constants, lane 0 only.
  localparam m31_t RC_INT [M31_RP] = '{
    31'h1A5C93E7, 31'h6D2B04F8, 31'h30E7A516, 31'h58F1C23B,
    31'h07B46D9A, 31'h4C9A18F0, 31'h7215E3C4, 31'h2387B05D,
    31'h5E60F927, 31'h11DA4C8E, 31'h69435B12, 31'h3CB8E07A,
    31'h45176DA3, 31'h0E2FC951
  };

endpackage

// File: rtl/m31_add.sv
// m31_add: combinational canonical adder modulo p = 2^31-1.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: i_a, i_b addends (0x7FFFFFFF accepted as 0); o_sum canonical result (< p).
module m31_add
  import m31_pkg::*;
(
  input  logic [30:0] i_a,
  input  logic [30:0] i_b,
  output logic [30:0] o_sum
);

  logic [31:0] w_s;
  logic [30:0] w_t;

  // 2^31 == 1 mod p, so the carry out of bit 30 folds back in as +1.
  // The fold cannot overflow: max sum 2^32-2 folds to exactly p.
  assign w_s   = {1'b0, i_a} + {1'b0, i_b};
  assign w_t   = w_s[30:0] + {30'd0, w_s[31]};
  assign o_sum = (w_t == P_M31) ? 31'd0 : w_t;

endmodule

// File: rtl/m31_ark.sv
// m31_ark: Poseidon2 M31 add-round-constant stage with round tracking and round-type sideband.
// Latency: 1 cycle; 2 cycles when M31_ARK_PIPE2_EN is defined (err_o stays 1 cycle).
// Backpressure: none, valid-only stream; every accepted beat emerges after the fixed latency.
// Ports: clk/rst (sync, active-high); valid_i/start_i/state_i beat in;
//        valid_o/state_o/round_o/partial_o/last_o beat out; err_o sticky protocol error.
// The constant tables in m31_pkg fix the geometry, so WIDTH/RF/RP must keep their defaults.
module m31_ark
  import m31_pkg::*;
#(
  parameter int WIDTH = M31_WIDTH,
  parameter int RF    = M31_RF,
  parameter int RP    = M31_RP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  input  logic                   start_i,
  input  logic [WIDTH-1:0][30:0] state_i,
  output logic                   valid_o,
  output logic [WIDTH-1:0][30:0] state_o,
  output logic [4:0]             round_o,
  output logic                   partial_o,
  output logic                   last_o,
  output logic                   err_o
);

  localparam logic [4:0] R_HALF = 5'(RF / 2);
  localparam logic [4:0] R_PEND = 5'(RF / 2 + RP);
  localparam logic [4:0] R_LAST = 5'(RF + RP - 1);
  localparam logic [4:0] R_RP   = 5'(RP);
  localparam int         EXT_W  = $clog2(RF);
  localparam int         INT_W  = $clog2(RP);

  ark_state_e             r_state;
  ark_state_e             w_state_nxt;
  logic [4:0]             r_rc;
  logic [4:0]             w_rc_nxt;
  logic                   w_accept;
  logic                   w_drop;
  logic [4:0]             w_round;
  logic                   w_partial;
  logic                   w_last;
  logic [EXT_W-1:0]       w_ext_idx;
  logic [INT_W-1:0]       w_int_idx;
  logic [WIDTH-1:0][30:0] w_const;
  logic [WIDTH-1:0][30:0] w_sum;

  logic                   r1_vld;
  logic [WIDTH-1:0][30:0] r1_state;
  logic [4:0]             r1_round;
  logic                   r1_partial;
  logic                   r1_last;
  logic                   r_err;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rc    <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rc    <= w_rc_nxt;
    end
  end

  // A start beat always restarts at round 0, even on the final round of
  // a running permutation; the next beat is then round 1.
  always_comb begin
    w_state_nxt = r_state;
    w_rc_nxt    = r_rc;
    if (valid_i && start_i) begin
      w_state_nxt = ST_RUN;
      w_rc_nxt    = 5'd1;
    end else if (valid_i && (r_state == ST_RUN)) begin
      if (r_rc == R_LAST) begin
        w_state_nxt = ST_IDLE;
        w_rc_nxt    = 5'd0;
      end else begin
        w_rc_nxt    = r_rc + 5'd1;
      end
    end
  end

  always_comb begin
    w_accept = valid_i && (start_i || (r_state == ST_RUN));
    w_drop   = valid_i && !start_i && (r_state == ST_IDLE);
    w_round  = start_i ? 5'd0 : r_rc;
  end

  // ---------------------------------------------------------------- constants
  assign w_partial = (w_round >= R_HALF) && (w_round < R_PEND);
  assign w_last    = (w_round == R_LAST);
  // Second-half full rounds reuse RC_EXT rows RF/2.. by skipping the RP partial rounds.
  // Both indices are computed every cycle; only the one matching w_partial is used.
  assign w_ext_idx = EXT_W'((w_round < R_HALF) ? w_round : (w_round - R_RP));
  assign w_int_idx = INT_W'(w_round - R_HALF);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    if (i == 0) begin : g_lane0
      assign w_const[i] = w_partial ? RC_INT[w_int_idx] : RC_EXT[w_ext_idx][i];
    end else begin : g_laneN
      assign w_const[i] = w_partial ? 31'd0 : RC_EXT[w_ext_idx][i];
    end

    m31_add u_add (
      .i_a   (state_i[i]),
      .i_b   (w_const[i]),
      .o_sum (w_sum[i])
    );
  end

  // ---------------------------------------------------------------- stage 1
  // Payload registers only load on accepted beats and otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_vld     <= 1'b0;
      r1_state   <= '0;
      r1_round   <= 5'd0;
      r1_partial <= 1'b0;
      r1_last    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r1_vld <= w_accept;
      if (w_accept) begin
        r1_state   <= w_sum;
        r1_round   <= w_round;
        r1_partial <= w_partial;
        r1_last    <= w_last;
      end
      r_err <= r_err | w_drop;
    end
  end

  assign err_o = r_err;

`ifdef M31_ARK_PIPE2_EN
  // ---------------------------------------------------------------- stage 2
  logic                   r2_vld;
  logic [WIDTH-1:0][30:0] r2_state;
  logic [4:0]             r2_round;
  logic                   r2_partial;
  logic                   r2_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_vld     <= 1'b0;
      r2_state   <= '0;
      r2_round   <= 5'd0;
      r2_partial <= 1'b0;
      r2_last    <= 1'b0;
    end else begin
      r2_vld <= r1_vld;
      if (r1_vld) begin
        r2_state   <= r1_state;
        r2_round   <= r1_round;
        r2_partial <= r1_partial;
        r2_last    <= r1_last;
      end
    end
  end

  assign valid_o   = r2_vld;
  assign state_o   = r2_state;
  assign round_o   = r2_round;
  assign partial_o = r2_partial;
  assign last_o    = r2_last;
`else
  assign valid_o   = r1_vld;
  assign state_o   = r1_state;
  assign round_o   = r1_round;
  assign partial_o = r1_partial;
  assign last_o    = r1_last;
`endif

endmodule

// File: doc/m31_ark.md
# m31_ark

Add-round-constant stage of the M31 Poseidon2 permutation datapath; sits directly upstream of the S-box bank (x^5 units) and feeds it.
- Each valid beat carries the full WIDTH-lane state for one round. The block tracks which round the beat belongs to and adds that round's constants modulo p = 2^31-1.
- The result is registered, together with round-type sideband the S-box bank and linear layer need: partial rounds apply the S-box to lane 0 only.
- Stream is valid-only with no backpressure, matching the fixed-latency S-box pipeline downstream.

## Interface
- WIDTH, 16, state lanes
- RF, 8, full (external) rounds, split RF/2 before and RF/2 after the partial rounds
- RP, 14, partial (internal) rounds
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  input beat valid
- start_i  in  1  qualifies valid_i: beat is round 0 of a new permutation
- state_i  in  WIDTH x 31  input state lanes (m31_t each)
- valid_o  out  1  output beat valid
- state_o  out  WIDTH x 31  state after constant addition, canonical (< p)
- round_o  out  5  round index of the output beat, 0..RF+RP-1
- partial_o  out  1  output beat is a partial round
- last_o  out  1  output beat is round RF+RP-1
- err_o  out  1  sticky: valid_i without start_i while IDLE; cleared only by rst

## Operation
- FSM states:
  - IDLE
    - valid_i & start_i → RUN, beat uses round 0.
    - valid_i & !start_i → beat dropped (no valid_o), err_o set.
  - RUN
    - Each valid_i beat uses the current round counter rc, then rc increments.
    - valid_i & start_i in RUN aborts the current permutation: beat uses round 0 and rc = 1 next.
    - Beat with rc = RF+RP-1 → IDLE; rc returns to 0. With start_i on that same beat, the start rule wins.
  - Cycles without valid_i never change rc or state.
- Round type:
  - full when rc < RF/2 or rc ≥ RF/2+RP; else partial.
- Constants from package:
  - Full round r: lane i += RC_EXT[e][i], with e = r for the first half and e = r-RP for the second half.
  - Partial round r: lane 0 += RC_INT[r-RF/2]; lanes 1..WIDTH-1 pass through unchanged.
- Modular add, per lane:
  - s = a + b, 32 bits.
  - t = s[30:0] + s[31].
  - Result = 0 if t == p, else t.
  - Non-canonical input 0x7FFFFFFF is treated as 0. Output is always < p.
- Reset:
  - valid_o, state_o, round_o, partial_o, last_o, err_o = 0.
  - FSM = IDLE, rc = 0.
  - Reset mid-permutation discards everything in flight; the next permutation requires start_i.

## Timing
- Latency 1 cycle, valid_i beat at edge n → valid_o at edge n+1 (default).
- Throughput one beat per cycle; back-to-back beats of the same permutation are allowed, since interleaving is the feedback loop's concern.
- state_o, round_o, partial_o, last_o hold their last values while valid_o = 0; they are don't-care to consumers.
- err_o asserts the cycle after the offending beat.

## Configuration
- M31_ARK_PIPE2_EN
  - Defined: a second register stage is added after the adders. Latency is 2 cycles; all outputs are delay-matched; reset clears both stages.
  - Undefined: single stage, latency 1.
- FSM and err_o timing are unaffected; err_o is still 1 cycle after the offending beat.

## Structure
- m31_pkg holds:
  - m31_t and P_M31 = 31'h7FFFFFFF.
  - Default WIDTH, RF, RP.
  - RC_EXT[RF][WIDTH] and RC_INT[RP] as m31_t localparam arrays.
- Sub-module m31_add: combinational canonical modular adder, instantiated WIDTH times.
- Round counter, FSM and constant selection live in m31_ark.

## Test plan
- Zero state with start_i, then 21 more consecutive beats of zero state:
  - Round 0 output = RC_EXT[0][*], round 4 lane0 = RC_INT[0] with other lanes 0.
  - round_o counts 0..21; partial_o high for rounds 4..17 only; last_o only on round 21.
- Overflow and canonical output, round 0:
  - Lane 0 = P_M31 - RC_EXT[0][0] → 0.
  - Lane 1 = 0x7FFFFFFE → RC_EXT[0][1]-1.
  - Lane 2 = 0x7FFFFFFF → RC_EXT[0][2].
- Stalls: valid_i gaps of 3 cycles between rounds → round_o still contiguous; no output during gaps.
- Protocol error:
  - valid_i without start_i after reset → no valid_o, err_o = 1 next cycle and stays 1.
  - A subsequent start beat still processes as round 0.
- Abort and reset:
  - start_i at round 7 → that output shows round_o = 0.
  - rst at round 10 → all outputs 0; next non-start beat is dropped.
- With M31_ARK_PIPE2_EN: repeat the first scenario; every output lands exactly 2 cycles after its input.
